// File: rtl/id_ex_stage_pkg.sv
// Shared ALU encodings for the ID/EX stage and the ALU: aluop classes,
// 3-bit ALU control codes, R-type funct values and the ID/EX register layout.
package id_ex_stage_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ADDI  = 2'b11
  } aluop_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        alusrc;
    logic        regdst;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        regwrite;
  } id_ex_regs_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side bundle into the ID/EX stage and the operand/control bundle out
// of it. The decode stage is the master; id_ex_stage is the slave.
interface id_ex_stage_if;

  logic        in_valid;
  logic [31:0] in_rd1;
  logic [31:0] in_rd2;
  logic [31:0] in_imm;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic        in_alusrc;
  logic        in_regdst;
  logic [1:0]  in_aluop;
  logic [5:0]  in_funct;
  logic        in_regwrite;

  logic        ex_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [4:0]  ex_dest;
  logic        ex_regwrite;
  logic [31:0] ex_store_data;
  logic        illegal_op;

  modport master (
    output in_valid, in_rd1, in_rd2, in_imm, in_rs, in_rt, in_rd,
           in_alusrc, in_regdst, in_aluop, in_funct, in_regwrite,
    input  ex_valid, alu_a, alu_b, alu_control, ex_dest, ex_regwrite,
           ex_store_data, illegal_op
  );

  modport slave (
    input  in_valid, in_rd1, in_rd2, in_imm, in_rs, in_rt, in_rd,
           in_alusrc, in_regdst, in_aluop, in_funct, in_regwrite,
    output ex_valid, alu_a, alu_b, alu_control, ex_dest, ex_regwrite,
           ex_store_data, illegal_op
  );

endinterface

// File: rtl/id_ex_stage_alu_decoder.sv
// Maps the aluop class and R-type funct to a 3-bit ALU control code.
// Unknown R-type functs fall back to add and raise illegal.
module alu_decoder
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (aluop_e'(aluop))
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_SLT: alu_control = ALU_SLT;
          default:   illegal     = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush control, operand forwarding from
// EX/MEM and MEM/WB, and ALU control decode of the registered instruction.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_dest,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_dest,
  input  logic [31:0] memwb_data,
  id_ex_stage_if.slave bus
);

  id_ex_regs_t r;
  logic [2:0]  dec_control;
  logic        dec_illegal;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  // A flush loads an all-zero bubble and wins over stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (flush) begin
      r <= '0;
    end else if (!stall) begin
      r.valid    <= bus.in_valid;
      r.rd1      <= bus.in_rd1;
      r.rd2      <= bus.in_rd2;
      r.imm      <= bus.in_imm;
      r.rs       <= bus.in_rs;
      r.rt       <= bus.in_rt;
      r.rd       <= bus.in_rd;
      r.alusrc   <= bus.in_alusrc;
      r.regdst   <= bus.in_regdst;
      r.aluop    <= bus.in_aluop;
      r.funct    <= bus.in_funct;
      r.regwrite <= bus.in_regwrite;
    end
  end

  // EX/MEM is the younger producer so it wins; register 0 is never forwarded.
  always_comb begin
    fwd_a = r.rd1;
    if (exmem_regwrite && (exmem_dest == r.rs) && (r.rs != 5'd0))
      fwd_a = exmem_result;
    else if (memwb_regwrite && (memwb_dest == r.rs) && (r.rs != 5'd0))
      fwd_a = memwb_data;

    fwd_b = r.rd2;
    if (exmem_regwrite && (exmem_dest == r.rt) && (r.rt != 5'd0))
      fwd_b = exmem_result;
    else if (memwb_regwrite && (memwb_dest == r.rt) && (r.rt != 5'd0))
      fwd_b = memwb_data;
  end

  alu_decoder u_alu_decoder (
    .aluop       (r.aluop),
    .funct       (r.funct),
    .alu_control (dec_control),
    .illegal     (dec_illegal)
  );

  assign bus.ex_valid      = r.valid;
  assign bus.ex_regwrite   = r.regwrite & r.valid;
  assign bus.ex_dest       = r.regdst ? r.rd : r.rt;
  assign bus.alu_a         = fwd_a;
  assign bus.ex_store_data = fwd_b;
  assign bus.alu_b         = r.alusrc ? r.imm : fwd_b;
  assign bus.alu_control   = dec_control;
  assign bus.illegal_op    = dec_illegal & r.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic checked against a behavioural model of the pipeline register.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        exmem_regwrite = 1'b0;
  logic [4:0]  exmem_dest = '0;
  logic [31:0] exmem_result = '0;
  logic        memwb_regwrite = 1'b0;
  logic [4:0]  memwb_dest = '0;
  logic [31:0] memwb_data = '0;

  int checks = 0;
  int errors = 0;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .exmem_regwrite (exmem_regwrite),
    .exmem_dest     (exmem_dest),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_dest     (memwb_dest),
    .memwb_data     (memwb_data),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently held in EX, as plain fields.
  logic        m_valid, m_alusrc, m_regdst, m_regwrite;
  logic [31:0] m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [1:0]  m_aluop;
  logic [5:0]  m_funct;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || (flush === 1'b1)) begin
      m_valid <= 0; m_regwrite <= 0; m_alusrc <= 0; m_regdst <= 0;
      m_rd1 <= 0; m_rd2 <= 0; m_imm <= 0; m_rs <= 0; m_rt <= 0; m_rd <= 0;
      m_aluop <= 0; m_funct <= 0;
    end else if (!stall) begin
      m_valid <= bus.in_valid; m_regwrite <= bus.in_regwrite;
      m_alusrc <= bus.in_alusrc; m_regdst <= bus.in_regdst;
      m_rd1 <= bus.in_rd1; m_rd2 <= bus.in_rd2; m_imm <= bus.in_imm;
      m_rs <= bus.in_rs; m_rt <= bus.in_rt; m_rd <= bus.in_rd;
      m_aluop <= bus.in_aluop; m_funct <= bus.in_funct;
    end
  end

  function automatic logic [31:0] exp_fwd(input logic [4:0] src, input logic [31:0] regval);
    if (src == 0) return regval;
    if (exmem_regwrite && exmem_dest == src) return exmem_result;
    if (memwb_regwrite && memwb_dest == src) return memwb_data;
    return regval;
  endfunction

  function automatic logic [2:0] exp_ctrl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b01) return 3'b110;
    if (op != 2'b10) return 3'b010;
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic exp_illegal(input logic v, input logic [1:0] op, input logic [5:0] fn);
    return v && op == 2'b10 && !(fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic alusrc, input logic regdst,
                       input logic [1:0] aluop, input logic [5:0] funct, input logic rw);
    bus.in_valid = v; bus.in_rd1 = rd1; bus.in_rd2 = rd2; bus.in_imm = imm;
    bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd; bus.in_alusrc = alusrc;
    bus.in_regdst = regdst; bus.in_aluop = aluop; bus.in_funct = funct;
    bus.in_regwrite = rw;
  endtask

  task automatic clear_fwd();
    exmem_regwrite = 0; exmem_dest = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_dest = 0; memwb_data = 0;
  endtask

  task automatic test_reset();
    clear_fwd();
    drive(1, 32'h1234, 32'h5678, 32'h9, 5'd1, 5'd2, 5'd3, 0, 1, 2'b10, 6'b100000, 1);
    rst_n = 0;
    step(); step();
    checks += 8;
    if (bus.ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", bus.ex_valid); end
    if (bus.ex_regwrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwrite got %b want 0", bus.ex_regwrite); end
    if (bus.ex_dest !== 5'd0) begin errors++; $display("[TB] FAIL reset_dest got %0d want 0", bus.ex_dest); end
    if (bus.illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal got %b want 0", bus.illegal_op); end
    if (bus.alu_control !== 3'b010) begin errors++; $display("[TB] FAIL reset_ctrl got %b want 010", bus.alu_control); end
    if (bus.alu_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_alu_a got %h want 0", bus.alu_a); end
    if (bus.alu_b !== 32'h0) begin errors++; $display("[TB] FAIL reset_alu_b got %h want 0", bus.alu_b); end
    if (bus.ex_store_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_store got %h want 0", bus.ex_store_data); end
    #3 rst_n = 1;
  endtask

  task automatic test_rtype_add();
    drive(1, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd9, 0, 1, 2'b10, 6'b100000, 1);
    step();
    checks += 6;
    if (bus.alu_control !== 3'b010) begin errors++; $display("[TB] FAIL add_ctrl got %b want 010", bus.alu_control); end
    if (bus.alu_a !== 32'd5) begin errors++; $display("[TB] FAIL add_alu_a got %0d want 5", bus.alu_a); end
    if (bus.alu_b !== 32'd7) begin errors++; $display("[TB] FAIL add_alu_b got %0d want 7", bus.alu_b); end
    if (bus.ex_dest !== 5'd9) begin errors++; $display("[TB] FAIL add_dest got %0d want 9", bus.ex_dest); end
    if (bus.ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid got %b want 1", bus.ex_valid); end
    if (bus.ex_regwrite !== 1'b1) begin errors++; $display("[TB] FAIL add_regwrite got %b want 1", bus.ex_regwrite); end
  endtask

  task automatic test_forward_priority();
    drive(1, 32'h11, 32'h22, 32'h0, 5'd3, 5'd3, 5'd4, 0, 1, 2'b00, 6'b0, 1);
    step();
    exmem_regwrite = 1; exmem_dest = 5'd3; exmem_result = 32'hAA;
    memwb_regwrite = 1; memwb_dest = 5'd3; memwb_data = 32'hBB;
    #1;
    checks += 4;
    if (bus.alu_a !== 32'hAA) begin errors++; $display("[TB] FAIL fwd_exmem_a got %h want aa", bus.alu_a); end
    if (bus.ex_store_data !== 32'hAA) begin errors++; $display("[TB] FAIL fwd_exmem_b got %h want aa", bus.ex_store_data); end
    exmem_regwrite = 0;
    #1;
    if (bus.alu_a !== 32'hBB) begin errors++; $display("[TB] FAIL fwd_memwb_a got %h want bb", bus.alu_a); end
    memwb_regwrite = 0;
    #1;
    if (bus.alu_a !== 32'h11) begin errors++; $display("[TB] FAIL fwd_none_a got %h want 11", bus.alu_a); end
    clear_fwd();
  endtask

  task automatic test_r0_forward();
    drive(1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5, 0, 1, 2'b10, 6'b100000, 1);
    step();
    exmem_regwrite = 1; exmem_dest = 5'd0; exmem_result = 32'hFFFF_FFFF;
    #1;
    checks += 3;
    if (bus.alu_a !== 32'h0) begin errors++; $display("[TB] FAIL r0_exmem_a got %h want 0", bus.alu_a); end
    exmem_regwrite = 0; memwb_regwrite = 1; memwb_dest = 5'd0; memwb_data = 32'hDEAD_BEEF;
    #1;
    if (bus.alu_a !== 32'h0) begin errors++; $display("[TB] FAIL r0_memwb_a got %h want 0", bus.alu_a); end
    if (bus.alu_b !== 32'h0) begin errors++; $display("[TB] FAIL r0_memwb_b got %h want 0", bus.alu_b); end
    clear_fwd();
  endtask

  task automatic test_stall_flush();
    drive(1, 32'h100, 32'h55, 32'hFFFF_FFFC, 5'd4, 5'd8, 5'd12, 1, 0, 2'b00, 6'b0, 1);
    stall = 1; flush = 1;
    step();
    checks += 2;
    if (bus.ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b want 0", bus.ex_valid); end
    if (bus.ex_regwrite !== 1'b0) begin errors++; $display("[TB] FAIL flush_regwrite got %b want 0", bus.ex_regwrite); end
    stall = 0; flush = 0;
    step();
    checks += 2;
    if (bus.alu_b !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL lw_alu_b got %h want fffffffc", bus.alu_b); end
    if (bus.ex_dest !== 5'd8) begin errors++; $display("[TB] FAIL lw_dest got %0d want 8", bus.ex_dest); end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, $urandom, $urandom, 5'd20, 5'd21, 5'd22, 0, 1, 2'b10, 6'b101010, 0);
      step();
      checks += 5;
      if (bus.alu_a !== 32'h100) begin errors++; $display("[TB] FAIL stall_alu_a cycle %0d got %h want 100", i, bus.alu_a); end
      if (bus.alu_b !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL stall_alu_b cycle %0d got %h want fffffffc", i, bus.alu_b); end
      if (bus.ex_dest !== 5'd8) begin errors++; $display("[TB] FAIL stall_dest cycle %0d got %0d want 8", i, bus.ex_dest); end
      if (bus.ex_valid !== 1'b1 || bus.ex_regwrite !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid cycle %0d got %b%b want 11", i, bus.ex_valid, bus.ex_regwrite); end
      if (bus.alu_control !== 3'b010) begin errors++; $display("[TB] FAIL stall_ctrl cycle %0d got %b want 010", i, bus.alu_control); end
    end
    stall = 0;
  endtask

  task automatic test_decode();
    drive(1, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, 0, 1, 2'b10, 6'b000000, 1);
    step();
    checks += 2;
    if (bus.illegal_op !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag got %b want 1", bus.illegal_op); end
    if (bus.alu_control !== 3'b010) begin errors++; $display("[TB] FAIL illegal_ctrl got %b want 010", bus.alu_control); end
    drive(1, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, 0, 1, 2'b10, 6'b101010, 1);
    step();
    checks += 2;
    if (bus.alu_control !== 3'b111) begin errors++; $display("[TB] FAIL slt_ctrl got %b want 111", bus.alu_control); end
    if (bus.illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL slt_illegal got %b want 0", bus.illegal_op); end
    for (int op = 0; op < 4; op++) begin
      for (int k = 0; k < 8; k++) begin
        logic [5:0] fn;
        fn = (k < 5) ? (k == 0 ? 6'b100000 : k == 1 ? 6'b100010 : k == 2 ? 6'b100100 :
                        k == 3 ? 6'b100101 : 6'b101010) : 6'($urandom);
        drive(1, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 0, 1, 2'(op), fn, 1);
        step();
        checks += 2;
        if (bus.alu_control !== exp_ctrl(2'(op), fn)) begin errors++; $display("[TB] FAIL decode_ctrl op %0d funct %b got %b want %b", op, fn, bus.alu_control, exp_ctrl(2'(op), fn)); end
        if (bus.illegal_op !== exp_illegal(1'b1, 2'(op), fn)) begin errors++; $display("[TB] FAIL decode_illegal op %0d funct %b got %b want %b", op, fn, bus.illegal_op, exp_illegal(1'b1, 2'(op), fn)); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), $urandom, $urandom, $urandom, 5'($urandom_range(0, 5)),
            5'($urandom_range(0, 5)), 5'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom), ($urandom_range(0, 1) == 1) ? 6'b100000 + 6'($urandom_range(0, 10)) : 6'($urandom),
            1'($urandom));
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      step();
      exmem_regwrite = 1'($urandom); exmem_dest = 5'($urandom_range(0, 5)); exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_dest = 5'($urandom_range(0, 5)); memwb_data = $urandom;
      #1;
      checks += 3;
      if (bus.ex_valid !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid iter %0d got %b want %b", i, bus.ex_valid, m_valid); end
      if (bus.ex_regwrite !== (m_valid & m_regwrite)) begin errors++; $display("[TB] FAIL rnd_regwrite iter %0d got %b want %b", i, bus.ex_regwrite, m_valid & m_regwrite); end
      if (bus.illegal_op !== exp_illegal(m_valid, m_aluop, m_funct)) begin errors++; $display("[TB] FAIL rnd_illegal iter %0d got %b want %b", i, bus.illegal_op, exp_illegal(m_valid, m_aluop, m_funct)); end
      if (m_valid) begin
        logic [31:0] ea, es, eb;
        ea = exp_fwd(m_rs, m_rd1);
        es = exp_fwd(m_rt, m_rd2);
        eb = m_alusrc ? m_imm : es;
        checks += 5;
        if (bus.alu_a !== ea) begin errors++; $display("[TB] FAIL rnd_alu_a iter %0d got %h want %h", i, bus.alu_a, ea); end
        if (bus.ex_store_data !== es) begin errors++; $display("[TB] FAIL rnd_store iter %0d got %h want %h", i, bus.ex_store_data, es); end
        if (bus.alu_b !== eb) begin errors++; $display("[TB] FAIL rnd_alu_b iter %0d got %h want %h", i, bus.alu_b, eb); end
        if (bus.ex_dest !== (m_regdst ? m_rd : m_rt)) begin errors++; $display("[TB] FAIL rnd_dest iter %0d got %0d want %0d", i, bus.ex_dest, m_regdst ? m_rd : m_rt); end
        if (bus.alu_control !== exp_ctrl(m_aluop, m_funct)) begin errors++; $display("[TB] FAIL rnd_ctrl iter %0d got %b want %b", i, bus.alu_control, exp_ctrl(m_aluop, m_funct)); end
      end
    end
    stall = 0; flush = 0;
    clear_fwd();
  endtask

  task automatic test_async_reset();
    drive(1, 32'h77, 32'h0, 32'h0, 5'd6, 5'd7, 5'd8, 0, 1, 2'b00, 6'b0, 1);
    step();
    checks += 1;
    if (bus.ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_valid got %b want 1", bus.ex_valid); end
    #3 rst_n = 0;
    #1;
    checks += 2;
    if (bus.ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid got %b want 0", bus.ex_valid); end
    if (bus.ex_regwrite !== 1'b0) begin errors++; $display("[TB] FAIL areset_regwrite got %b want 0", bus.ex_regwrite); end
    #1 rst_n = 1;
    drive(1, 32'h99, 32'h0, 32'h0, 5'd6, 5'd7, 5'd8, 0, 1, 2'b00, 6'b0, 1);
    step();
    checks += 2;
    if (bus.ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_valid got %b want 1", bus.ex_valid); end
    if (bus.alu_a !== 32'h99) begin errors++; $display("[TB] FAIL post_reset_alu_a got %h want 99", bus.alu_a); end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_rtype_add();
    test_forward_priority();
    test_r0_forward();
    test_stall_flush();
    test_decode();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have inputs stall (1, hold register) and flush (1, insert bubble).
REQ-004 SHALL have decode inputs: in_valid 1; in_rd1 32; in_rd2 32; in_imm 32 (sign-extended); in_rs 5; in_rt 5; in_rd 5; in_alusrc 1; in_regdst 1; in_aluop 2; in_funct 6; in_regwrite 1.
REQ-005 SHALL have forwarding inputs: exmem_regwrite 1; exmem_dest 5; exmem_result 32; memwb_regwrite 1; memwb_dest 5; memwb_data 32.
REQ-006 SHALL have outputs: ex_valid 1; alu_a 32; alu_b 32; alu_control 3; ex_dest 5; ex_regwrite 1; ex_store_data 32; illegal_op 1.

Function
REQ-007 SHALL register all decode inputs on a clock edge when flush=0 and stall=0; latency exactly 1 cycle.
REQ-008 SHALL, on flush=1, load a bubble: ex_valid=0, ex_regwrite=0; flush dominates stall.
REQ-009 SHALL, on stall=1 and flush=0, hold every register unchanged.
REQ-010 SHALL gate regwrite: ex_regwrite = registered in_regwrite AND ex_valid.
REQ-011 SHALL select ex_dest = rd if registered regdst=1, else rt.
REQ-012 SHALL decode alu_control: aluop 00 -> 010 (add); 01 -> 110 (subtract); 10 -> by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; aluop 11 -> 010.
REQ-013 SHALL assert illegal_op when ex_valid=1, aluop=10 and funct not in the REQ-012 list; alu_control then 010.
REQ-014 SHALL forward operand A (register rs): if exmem_regwrite and exmem_dest==rs and rs!=0 -> exmem_result; else if memwb_regwrite and memwb_dest==rs and rs!=0 -> memwb_data; else registered rd1.
REQ-015 SHALL forward the rt operand identically (rt, rd2) giving ex_store_data.
REQ-016 SHALL drive alu_b = registered imm if alusrc=1, else ex_store_data.
REQ-017 SHALL compute forwarding and decode combinationally from registered state and current forwarding inputs; EX/MEM priority over MEM/WB on simultaneous match.
REQ-018 SHALL never forward for register 0, even when a producer writes dest 0.

Reset
REQ-019 SHALL clear all registers to zero while rst_n=0, independent of clk: ex_valid=0, ex_regwrite=0, ex_dest=0, illegal_op=0, alu_control=010, alu_a/alu_b/ex_store_data=0 when forwarding inputs are inactive.
REQ-020 SHALL discard any in-flight instruction on reset mid-operation; first capture on first rising edge after rst_n rises with stall=0.

Structure
REQ-021 SHALL take the aluop codes and five 3-bit control codes (010, 110, 000, 001, 111) from a shared package also used by the ALU.
REQ-022 SHALL place REQ-012/013 decode in sub-module alu_decoder (aluop, funct -> control, illegal).
REQ-023 SHALL keep forwarding muxes in id_ex_stage; no other sub-modules.

Verification
REQ-024 Bench SHALL cover: R-type add, rd1=5, rd2=7, funct 100000, no forwarding -> next cycle alu_control=010, alu_a=5, alu_b=7, ex_dest=rd.
REQ-025 Bench SHALL cover: exmem_dest=memwb_dest=rs=3, exmem_result=0xAA, memwb_data=0xBB -> alu_a=0xAA; drop exmem_regwrite -> alu_a=0xBB.
REQ-026 Bench SHALL cover: rs=0, exmem_regwrite=1, exmem_dest=0, exmem_result=0xFFFF_FFFF, rd1=0 -> alu_a=0.
REQ-027 Bench SHALL cover: stall=1 and flush=1 same cycle with valid lw (alusrc=1, imm=-4) -> ex_valid=0, ex_regwrite=0; stall alone -> outputs unchanged for 3 cycles.
REQ-028 Bench SHALL cover: aluop=10, funct 000000 -> illegal_op=1, alu_control=010; slt funct 101010 -> alu_control=111, illegal_op=0.
REQ-029 Bench SHALL cover: rst_n low mid-stream between clock edges -> ex_valid and ex_regwrite fall to 0 immediately, before next edge.
